// File: rtl/ct_had_bkpt_sqc_pkg.sv
// Shared HAD definitions for the memory-breakpoint sequence controller.
package ct_had_bkpt_sqc_pkg;

  typedef enum logic [1:0] {
    SQC_OR  = 2'b00,
    SQC_AB  = 2'b01,
    SQC_BA  = 2'b10,
    SQC_AND = 2'b11
  } sqc_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArmed = 2'b01,
    StReq   = 2'b10,
    StHalt  = 2'b11
  } sqc_state_e;

endpackage

// File: rtl/ct_had_bkpt_sqc.sv
// Level-four memory-breakpoint sequencing: combines A/B hits by HCR mode into one
// held debug request and keeps sticky per-breakpoint hit status.
module ct_had_bkpt_sqc
  import ct_had_bkpt_sqc_pkg::*;
(
  input  logic       cpuclk,
  input  logic       cpurst_b,
  input  logic       bkpta_inst_req,
  input  logic       bkpta_data_req,
  input  logic       bkptb_inst_req,
  input  logic       bkptb_data_req,
  input  logic [1:0] regs_xx_sqc_mode,
  input  logic       ctrl_sqc_en,
  input  logic       ctrl_sqc_ack,
  input  logic       rtu_yy_xx_dbgon,
  input  logic       x_sm_xx_update_dr_en,
  input  logic       ir_xx_hcr_reg_sel,
  input  logic       ir_xx_mbs_reg_sel,
  output logic       sqc_ctrl_dbgreq,
  output logic [1:0] sqc_ctrl_src,
  output logic       sqc_regs_armed,
  output logic [3:0] sqc_regs_mbs
);

  sqc_mode_e  mode;
  sqc_state_e state_q, state_d;
  logic       req_en;
  logic [3:0] raw_req;
  logic       hit_a, hit_b;
  logic       cfg_wr, mbs_clr;
  logic [1:0] src_q, src_d;
  logic [3:0] mbs_q, mbs_d;

  assign mode    = sqc_mode_e'(regs_xx_sqc_mode);
  assign req_en  = ctrl_sqc_en & ~rtu_yy_xx_dbgon;
  assign raw_req = {4{req_en}} & {bkptb_data_req, bkptb_inst_req,
                                  bkpta_data_req, bkpta_inst_req};
  assign hit_a   = raw_req[0] | raw_req[1];
  assign hit_b   = raw_req[2] | raw_req[3];
  assign cfg_wr  = x_sm_xx_update_dr_en & ir_xx_hcr_reg_sel;
  assign mbs_clr = x_sm_xx_update_dr_en & ir_xx_mbs_reg_sel;

  // State register
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!cfg_wr) begin
          unique case (mode)
            SQC_OR:  if (hit_a | hit_b) state_d = StReq;
            SQC_AND: if (hit_a & hit_b) state_d = StReq;
            SQC_AB:  if (hit_a)         state_d = StArmed;
            SQC_BA:  if (hit_b)         state_d = StArmed;
          endcase
        end
      end
      StArmed: begin
        // A config write or loss of enable disarms; the completing hit loses to both.
        if (cfg_wr || !ctrl_sqc_en) begin
          state_d = StIdle;
        end else if ((mode == SQC_AB && hit_b) || (mode == SQC_BA && hit_a)) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (ctrl_sqc_ack || rtu_yy_xx_dbgon) state_d = StHalt;
      end
      StHalt: begin
        if (!rtu_yy_xx_dbgon) state_d = StIdle;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    sqc_ctrl_dbgreq = (state_q == StReq);
    sqc_regs_armed  = (state_q == StArmed);
  end

  // Source capture on entry to REQ, held while in REQ, cleared otherwise
  always_comb begin
    src_d = src_q;
    if (state_d != StReq) begin
      src_d = 2'b00;
    end else if (state_q != StReq) begin
      src_d = (mode == SQC_OR) ? {hit_b, hit_a} : 2'b11;
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      src_q <= 2'b00;
    end else begin
      src_q <= src_d;
    end
  end

  assign sqc_ctrl_src = src_q;

  // Sticky hit status; a clear beats a same-cycle set
  always_comb begin
    mbs_d = mbs_q | raw_req;
    if (mbs_clr) mbs_d = 4'b0000;
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      mbs_q <= 4'b0000;
    end else begin
      mbs_q <= mbs_d;
    end
  end

  assign sqc_regs_mbs = mbs_q;

endmodule

// File: tb/tb_ct_had_bkpt_sqc.sv
// Directed table-driven bench for ct_had_bkpt_sqc plus a few hand sequences
// for asynchronous reset and request qualification.
module tb_ct_had_bkpt_sqc;

  logic       cpuclk;
  logic       cpurst_b;
  logic       bkpta_inst_req, bkpta_data_req, bkptb_inst_req, bkptb_data_req;
  logic [1:0] regs_xx_sqc_mode;
  logic       ctrl_sqc_en, ctrl_sqc_ack, rtu_yy_xx_dbgon;
  logic       x_sm_xx_update_dr_en, ir_xx_hcr_reg_sel, ir_xx_mbs_reg_sel;
  logic       sqc_ctrl_dbgreq;
  logic [1:0] sqc_ctrl_src;
  logic       sqc_regs_armed;
  logic [3:0] sqc_regs_mbs;

  int n_tests;
  int n_fail;

  ct_had_bkpt_sqc dut (
    .cpuclk               (cpuclk),
    .cpurst_b             (cpurst_b),
    .bkpta_inst_req       (bkpta_inst_req),
    .bkpta_data_req       (bkpta_data_req),
    .bkptb_inst_req       (bkptb_inst_req),
    .bkptb_data_req       (bkptb_data_req),
    .regs_xx_sqc_mode     (regs_xx_sqc_mode),
    .ctrl_sqc_en          (ctrl_sqc_en),
    .ctrl_sqc_ack         (ctrl_sqc_ack),
    .rtu_yy_xx_dbgon      (rtu_yy_xx_dbgon),
    .x_sm_xx_update_dr_en (x_sm_xx_update_dr_en),
    .ir_xx_hcr_reg_sel    (ir_xx_hcr_reg_sel),
    .ir_xx_mbs_reg_sel    (ir_xx_mbs_reg_sel),
    .sqc_ctrl_dbgreq      (sqc_ctrl_dbgreq),
    .sqc_ctrl_src         (sqc_ctrl_src),
    .sqc_regs_armed       (sqc_regs_armed),
    .sqc_regs_mbs         (sqc_regs_mbs)
  );

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  // req = {bd, bi, ad, ai}; ctl = {en, ack, dbgon, upd, hcr_sel, mbs_sel}
  typedef struct {
    logic [1:0] mode;
    logic [3:0] req;
    logic [5:0] ctl;
    logic       e_req;
    logic [1:0] e_src;
    logic       e_arm;
    logic [3:0] e_mbs;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] m, input logic [3:0] r, input logic [5:0] c,
                              input logic er, input logic [1:0] es, input logic ea,
                              input logic [3:0] em);
    vec_t v;
    v.mode = m; v.req = r; v.ctl = c;
    v.e_req = er; v.e_src = es; v.e_arm = ea; v.e_mbs = em;
    return v;
  endfunction

  task automatic drive(input logic [1:0] m, input logic [3:0] r, input logic [5:0] c);
    regs_xx_sqc_mode = m;
    {bkptb_data_req, bkptb_inst_req, bkpta_data_req, bkpta_inst_req} = r;
    {ctrl_sqc_en, ctrl_sqc_ack, rtu_yy_xx_dbgon,
     x_sm_xx_update_dr_en, ir_xx_hcr_reg_sel, ir_xx_mbs_reg_sel} = c;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {sqc_ctrl_dbgreq, sqc_ctrl_src, sqc_regs_armed, sqc_regs_mbs};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {req,src,arm,mbs}=%b_%b_%b_%b expected %b_%b_%b_%b", name,
               got[7], got[6:5], got[4], got[3:0], exp[7], exp[6:5], exp[4], exp[3:0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cpurst_b = 1'b0;
    drive(2'b00, 4'b0000, 6'b000000);

    //                 mode   {bd,bi,ad,ai} {en,ack,dbg,upd,hcr,mbs} req src  arm mbs
    // mode 00
    vecs.push_back(mk(2'b00, 4'b0000, 6'b100000, 0, 2'b00, 0, 4'b0000)); // 0 idle
    vecs.push_back(mk(2'b00, 4'b0010, 6'b100000, 1, 2'b01, 0, 4'b0010)); // 1 A data
    vecs.push_back(mk(2'b00, 4'b0000, 6'b100000, 1, 2'b01, 0, 4'b0010)); // 2 held
    vecs.push_back(mk(2'b00, 4'b0000, 6'b111000, 0, 2'b00, 0, 4'b0010)); // 3 ack+dbgon
    vecs.push_back(mk(2'b00, 4'b0000, 6'b101000, 0, 2'b00, 0, 4'b0010)); // 4 halt
    vecs.push_back(mk(2'b00, 4'b0100, 6'b101000, 0, 2'b00, 0, 4'b0010)); // 5 hit under dbgon
    vecs.push_back(mk(2'b00, 4'b0000, 6'b100000, 0, 2'b00, 0, 4'b0010)); // 6 -> idle
    vecs.push_back(mk(2'b00, 4'b0000, 6'b100101, 0, 2'b00, 0, 4'b0000)); // 7 mbs clear
    // mode 01
    vecs.push_back(mk(2'b01, 4'b1000, 6'b100000, 0, 2'b00, 0, 4'b1000)); // 8 B alone
    vecs.push_back(mk(2'b01, 4'b0001, 6'b100000, 0, 2'b00, 1, 4'b1001)); // 9 A arms
    vecs.push_back(mk(2'b01, 4'b0001, 6'b100000, 0, 2'b00, 1, 4'b1001)); // 10 repeat A
    vecs.push_back(mk(2'b01, 4'b0100, 6'b100000, 1, 2'b11, 0, 4'b1101)); // 11 B completes
    vecs.push_back(mk(2'b01, 4'b0000, 6'b111000, 0, 2'b00, 0, 4'b1101)); // 12 ack
    vecs.push_back(mk(2'b01, 4'b0000, 6'b100000, 0, 2'b00, 0, 4'b1101)); // 13 -> idle
    vecs.push_back(mk(2'b01, 4'b0001, 6'b100101, 0, 2'b00, 1, 4'b0000)); // 14 clear beats set
    vecs.push_back(mk(2'b01, 4'b0100, 6'b100110, 0, 2'b00, 0, 4'b0100)); // 15 HCR wr beats B
    vecs.push_back(mk(2'b01, 4'b0101, 6'b100000, 0, 2'b00, 1, 4'b0101)); // 16 A+B together
    vecs.push_back(mk(2'b01, 4'b1000, 6'b100000, 1, 2'b11, 0, 4'b1101)); // 17 B next
    vecs.push_back(mk(2'b01, 4'b0000, 6'b100110, 1, 2'b11, 0, 4'b1101)); // 18 HCR wr in REQ
    vecs.push_back(mk(2'b01, 4'b0000, 6'b000000, 1, 2'b11, 0, 4'b1101)); // 19 en low in REQ
    vecs.push_back(mk(2'b01, 4'b0000, 6'b110000, 0, 2'b00, 0, 4'b1101)); // 20 ack alone
    vecs.push_back(mk(2'b01, 4'b0000, 6'b100000, 0, 2'b00, 0, 4'b1101)); // 21 idle
    // mode 10
    vecs.push_back(mk(2'b10, 4'b0001, 6'b100000, 0, 2'b00, 0, 4'b1101)); // 22 A first: no arm
    vecs.push_back(mk(2'b10, 4'b0100, 6'b100000, 0, 2'b00, 1, 4'b1101)); // 23 B arms
    vecs.push_back(mk(2'b10, 4'b0000, 6'b000000, 0, 2'b00, 0, 4'b1101)); // 24 en low disarms
    vecs.push_back(mk(2'b10, 4'b0100, 6'b100000, 0, 2'b00, 1, 4'b1101)); // 25 rearm
    vecs.push_back(mk(2'b10, 4'b0010, 6'b100000, 1, 2'b11, 0, 4'b1111)); // 26 A completes
    vecs.push_back(mk(2'b10, 4'b0000, 6'b101000, 0, 2'b00, 0, 4'b1111)); // 27 dbgon alone
    vecs.push_back(mk(2'b10, 4'b0000, 6'b100000, 0, 2'b00, 0, 4'b1111)); // 28 idle
    // mode 11
    vecs.push_back(mk(2'b11, 4'b0001, 6'b100101, 0, 2'b00, 0, 4'b0000)); // 29 clear, A only
    vecs.push_back(mk(2'b11, 4'b0001, 6'b100000, 0, 2'b00, 0, 4'b0001)); // 30 A only
    vecs.push_back(mk(2'b11, 4'b1001, 6'b100000, 1, 2'b11, 0, 4'b1001)); // 31 A and B
    vecs.push_back(mk(2'b11, 4'b0000, 6'b110000, 0, 2'b00, 0, 4'b1001)); // 32 ack
    vecs.push_back(mk(2'b11, 4'b0000, 6'b100000, 0, 2'b00, 0, 4'b1001)); // 33 idle
    // mode 00 source capture and re-trigger spacing
    vecs.push_back(mk(2'b00, 4'b0100, 6'b100000, 1, 2'b10, 0, 4'b1101)); // 34 B only
    vecs.push_back(mk(2'b00, 4'b0000, 6'b111000, 0, 2'b00, 0, 4'b1101)); // 35 ack
    vecs.push_back(mk(2'b00, 4'b0000, 6'b100000, 0, 2'b00, 0, 4'b1101)); // 36 idle
    vecs.push_back(mk(2'b00, 4'b0101, 6'b100000, 1, 2'b11, 0, 4'b1101)); // 37 A and B
    vecs.push_back(mk(2'b00, 4'b0000, 6'b111000, 0, 2'b00, 0, 4'b1101)); // 38 ack
    vecs.push_back(mk(2'b00, 4'b0000, 6'b100000, 0, 2'b00, 0, 4'b1101)); // 39 dbgon fell
    vecs.push_back(mk(2'b00, 4'b0001, 6'b100000, 1, 2'b01, 0, 4'b1101)); // 40 re-trigger

    repeat (3) @(posedge cpuclk);
    #1 check("reset", 8'h00);
    @(negedge cpuclk);
    cpurst_b = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge cpuclk);
      drive(vecs[i].mode, vecs[i].req, vecs[i].ctl);
      @(posedge cpuclk);
      #1 check($sformatf("vec%0d", i),
               {vecs[i].e_req, vecs[i].e_src, vecs[i].e_arm, vecs[i].e_mbs});
    end

    // Asynchronous reset while REQ is held clears everything at once
    drive(2'b00, 4'b0000, 6'b100000);
    #2 cpurst_b = 1'b0;
    #1 check("async_reset_mid_req", 8'h00);
    @(negedge cpuclk);
    cpurst_b = 1'b1;

    // Disabled: hits neither request nor record
    drive(2'b00, 4'b1111, 6'b000000);
    @(posedge cpuclk);
    #1 check("disabled_hit", 8'h00);

    // Debug mode: hits ignored from IDLE
    @(negedge cpuclk);
    drive(2'b00, 4'b0011, 6'b101000);
    @(posedge cpuclk);
    #1 check("dbgon_hit_ignored", 8'h00);

    // Same hit once debug mode is gone
    @(negedge cpuclk);
    drive(2'b00, 4'b0011, 6'b100000);
    @(posedge cpuclk);
    #1 check("hit_after_dbgon", {1'b1, 2'b01, 1'b0, 4'b0011});

    @(negedge cpuclk);
    drive(2'b00, 4'b0000, 6'b000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
